// File: rtl/fact_bus_master_if.sv
// Bus between the factorial bus master and the arbiter/factorial-core side.
// The master drives request, direction, address and write data; the far side returns grant and read data.
interface fact_bus_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic              m_grant;
  logic [DATA_W-1:0] m_din;

  modport master (
    output m_req, m_wr, m_addr, m_dout,
    input  m_grant, m_din
  );

  modport slave (
    input  m_req, m_wr, m_addr, m_dout,
    output m_grant, m_din
  );
endinterface

// File: rtl/fact_bus_master.sv
// Bus master that runs the operand/start/poll/result/clear program against the factorial core.
// Optional poll timeout is enabled by defining FACT_BUS_MASTER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for host start
// REQ     | bus requested, waiting for grant
// WR_OP   | writing operand to OPERAND
// WR_GO   | writing 1 to START
// RD_ST   | read address STATUS on the bus
// CHK_ST  | status data returned, test done bit
// RD_RES  | read address RESULT on the bus
// CAP_RES | result data returned, capture it
// WR_CLR  | writing 1 to CLEAR
// REL     | bus released, done pulse
module fact_bus_master #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] operand_i,
  fact_bus_master_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              err_o
);

  typedef enum logic [3:0] {
    IDLE, REQ, WR_OP, WR_GO, RD_ST, CHK_ST, RD_RES, CAP_RES, WR_CLR, REL
  } state_t;

  localparam logic [ADDR_W-1:0] A_OPERAND = BASE_ADDR;
  localparam logic [ADDR_W-1:0] A_START   = BASE_ADDR + ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STATUS  = BASE_ADDR + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RESULT  = BASE_ADDR + ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CLEAR   = BASE_ADDR + ADDR_W'(4);

  state_t            state_q, state_d;
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef FACT_BUS_MASTER_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      stall_q  <= 1'b0;
      op_q     <= '0;
      result_q <= '0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FACT_BUS_MASTER_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      op_q     <= op_d;
      result_q <= result_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef FACT_BUS_MASTER_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    stall_d  = 1'b0;
    op_d     = op_q;
    result_d = result_q;
`ifdef FACT_BUS_MASTER_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d    = operand_i;
          state_d = REQ;
`ifdef FACT_BUS_MASTER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      REQ: begin
        if (bus.m_grant) state_d = WR_OP;
      end
      REL: state_d = IDLE;
      default: begin
        // Outputs are registered, so a write seen with m_wr forced low during a
        // stall must be re-driven for one granted cycle before it can complete.
        if (!bus.m_grant) begin
          stall_d = 1'b1;
        end else if (!stall_q) begin
          case (state_q)
            WR_OP: begin
              state_d = WR_GO;
`ifdef FACT_BUS_MASTER_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end
            WR_GO:  state_d = RD_ST;
            RD_ST:  state_d = CHK_ST;
            CHK_ST: begin
              if (bus.m_din[0]) begin
                state_d = RD_RES;
              end else begin
`ifdef FACT_BUS_MASTER_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd254) begin
                  err_d   = 1'b1;
                  state_d = WR_CLR;
                end else begin
                  state_d = RD_ST;
                end
`else
                state_d = RD_ST;
`endif
              end
            end
            RD_RES: state_d = CAP_RES;
            CAP_RES: begin
              result_d = bus.m_din;
              state_d  = WR_CLR;
            end
            WR_CLR: state_d = REL;
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    req_d  = (state_d != IDLE) && (state_d != REL);
    busy_d = (state_d != IDLE) && (state_d != REL);
    done_d = (state_d == REL);
    wr_d   = ((state_d == WR_OP) || (state_d == WR_GO) || (state_d == WR_CLR)) && !stall_d;
    addr_d = addr_q;
    dout_d = dout_q;
    case (state_d)
      WR_OP: begin
        addr_d = A_OPERAND;
        dout_d = op_d;
      end
      WR_GO: begin
        addr_d = A_START;
        dout_d = DATA_W'(1);
      end
      RD_ST:  addr_d = A_STATUS;
      RD_RES: addr_d = A_RESULT;
      WR_CLR: begin
        addr_d = A_CLEAR;
        dout_d = DATA_W'(1);
      end
      default: ;
    endcase
  end

  assign bus.m_req  = req_q;
  assign bus.m_wr   = wr_q;
  assign bus.m_addr = addr_q;
  assign bus.m_dout = dout_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
`ifdef FACT_BUS_MASTER_TIMEOUT_EN
  assign err_o      = err_q;
`else
  assign err_o      = 1'b0;
`endif

endmodule
